// File: rtl/ddr_cas_responder.sv
// ddr_cas_responder: device-side model of the DRAM CAS path.
// Accepts READ/WRITE commands (optionally with auto-precharge), holds them in a
// small pending queue, and runs each data burst after RL = AL+CL (reads) or
// WL = AL+CWL (writes). Each data word packs both DDR edges of one CK_t cycle.
//
// cas_req encodings (local mirror of ddr_pkg):
//   RD_R = 3'd0, RDA_R = 3'd1, WR_R = 3'd2, WRA_R = 3'd3. Other codes are ignored.
//
// Ports:
//   CK_t, reset_n            clock, async active-low reset
//   CL, CWL, AL, BL, tCCD    timing settings, latched per command at acceptance
//   cas_valid/req/addr       command input
//   mem_rd_en/addr/data      storage read port, data valid one cycle after enable
//   mem_wr_en/addr/data      storage write port, registered
//   dq_out, dq_oe, dq_in     data bus toward the controller
//   rw_done, ap_done         burst / auto-precharge completion pulses
//   busy                     queue non-empty or burst active
//   err_tccd/overflow/bus_conflict   one-cycle violation pulses
module ddr_cas_responder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              CK_t,
  input  logic              reset_n,
  input  logic [4:0]        CL,
  input  logic [4:0]        CWL,
  input  logic [4:0]        AL,
  input  logic [4:0]        BL,
  input  logic [3:0]        tCCD,
  input  logic              cas_valid,
  input  logic [2:0]        cas_req,
  input  logic [ADDR_W-1:0] cas_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [DATA_W-1:0] dq_out,
  output logic              dq_oe,
  input  logic [DATA_W-1:0] dq_in,
  output logic              rw_done,
  output logic              ap_done,
  output logic              busy,
  output logic              err_tccd,
  output logic              err_overflow,
  output logic              err_bus_conflict
);

  localparam logic [2:0] RD_R  = 3'd0;
  localparam logic [2:0] RDA_R = 3'd1;
  localparam logic [2:0] WR_R  = 3'd2;
  localparam logic [2:0] WRA_R = 3'd3;

  localparam logic [1:0] BURST_IDLE = 2'd0;
  localparam logic [1:0] BURST_RD   = 2'd1;
  localparam logic [1:0] BURST_WR   = 2'd2;

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Command decode and latency
  logic       cmd_legal, cmd_wr, cmd_ap;
  logic [5:0] rl, wl, lat_raw, lat;
  logic       accept, full;

  always_comb begin
    cmd_legal = 1'b1;
    cmd_wr    = 1'b0;
    cmd_ap    = 1'b0;
    case (cas_req)
      RD_R:  ;
      RDA_R: cmd_ap = 1'b1;
      WR_R:  cmd_wr = 1'b1;
      WRA_R: begin
        cmd_wr = 1'b1;
        cmd_ap = 1'b1;
      end
      default: cmd_legal = 1'b0;
    endcase
  end

  assign rl      = {1'b0, AL} + {1'b0, CL};
  assign wl      = {1'b0, AL} + {1'b0, CWL};
  assign lat_raw = cmd_wr ? wl : rl;
  assign lat     = (lat_raw < 6'd2) ? 6'd2 : lat_raw;

  // Pending queue, kept compacted in acceptance order (index 0 is oldest)
  logic              q_wr_q   [DEPTH];
  logic              q_ap_q   [DEPTH];
  logic              q_bl4_q  [DEPTH];
  logic [ADDR_W-1:0] q_addr_q [DEPTH];
  logic [5:0]        q_cnt_q  [DEPTH];
  logic              q_wr_d   [DEPTH];
  logic              q_ap_d   [DEPTH];
  logic              q_bl4_d  [DEPTH];
  logic [ADDR_W-1:0] q_addr_d [DEPTH];
  logic [5:0]        q_cnt_d  [DEPTH];
  logic [CW-1:0]     count_q, count_d, n;

  assign full   = (count_q == CW'(DEPTH));
  assign accept = cas_valid && cmd_legal && !full;

  // Burst engine state
  logic [1:0]        state_q, state_d;
  logic [1:0]        beat_q, beat_d, last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ap_q, ap_d;
  logic              at_last, can_start;

  assign at_last   = (state_q != BURST_IDLE) && (beat_q == last_q);
  assign can_start = (state_q == BURST_IDLE) || at_last;

  logic              start_vld, start_wr, start_ap, start_bl4, drop;
  logic [ADDR_W-1:0] start_addr;

  // An entry with countdown 1 is due: it either starts its burst next cycle or is
  // dropped as a bus conflict. Only the oldest due entry can win the bus.
  always_comb begin
    n          = '0;
    start_vld  = 1'b0;
    start_wr   = 1'b0;
    start_ap   = 1'b0;
    start_bl4  = 1'b0;
    start_addr = '0;
    drop       = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      q_wr_d[j]   = 1'b0;
      q_ap_d[j]   = 1'b0;
      q_bl4_d[j]  = 1'b0;
      q_addr_d[j] = '0;
      q_cnt_d[j]  = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(count_q)) begin
        if (q_cnt_q[i] == 6'd1) begin
          if (!start_vld && can_start) begin
            start_vld  = 1'b1;
            start_wr   = q_wr_q[i];
            start_ap   = q_ap_q[i];
            start_bl4  = q_bl4_q[i];
            start_addr = q_addr_q[i];
          end else begin
            drop = 1'b1;
          end
        end else begin
          q_wr_d[n[IW-1:0]]   = q_wr_q[i];
          q_ap_d[n[IW-1:0]]   = q_ap_q[i];
          q_bl4_d[n[IW-1:0]]  = q_bl4_q[i];
          q_addr_d[n[IW-1:0]] = q_addr_q[i];
          q_cnt_d[n[IW-1:0]]  = q_cnt_q[i] - 6'd1;
          n = n + CW'(1);
        end
      end
    end
    if (accept) begin
      q_wr_d[n[IW-1:0]]   = cmd_wr;
      q_ap_d[n[IW-1:0]]   = cmd_ap;
      q_bl4_d[n[IW-1:0]]  = (BL == 5'd4);
      q_addr_d[n[IW-1:0]] = cas_addr;
      q_cnt_d[n[IW-1:0]]  = lat - 6'd1;
      n = n + CW'(1);
    end
    count_d = n;
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    last_d  = last_q;
    ap_d    = ap_q;
    if (start_vld) begin
      state_d = start_wr ? BURST_WR : BURST_RD;
      beat_d  = 2'd0;
      addr_d  = start_addr;
      last_d  = start_bl4 ? 2'd1 : 2'd3;
      ap_d    = start_ap;
    end else if (at_last) begin
      state_d = BURST_IDLE;
      beat_d  = 2'd0;
    end else if (state_q != BURST_IDLE) begin
      beat_d = beat_q + 2'd1;
    end
  end

  // Storage reads run one cycle ahead of the beat they feed.
  always_comb begin
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    if (start_vld && !start_wr) begin
      mem_rd_en   = 1'b1;
      mem_rd_addr = start_addr;
    end else if (state_q == BURST_RD && !at_last) begin
      mem_rd_en   = 1'b1;
      mem_rd_addr = addr_q + ADDR_W'(beat_q) + ADDR_W'(1);
    end
  end

  // tCCD spacing: cycles since the last accepted command, saturating at 15
  logic [3:0] sp_q, sp_d;
  assign sp_d = accept ? 4'd1 : ((sp_q == 4'd15) ? sp_q : sp_q + 4'd1);

  logic              mem_wr_en_q, rw_done_q, ap_done_q;
  logic              err_tccd_q, err_overflow_q, err_bus_conflict_q;
  logic [ADDR_W-1:0] mem_wr_addr_q;
  logic [DATA_W-1:0] mem_wr_data_q;

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      count_q            <= '0;
      state_q            <= BURST_IDLE;
      beat_q             <= 2'd0;
      last_q             <= 2'd0;
      addr_q             <= '0;
      ap_q               <= 1'b0;
      sp_q               <= 4'd15;
      mem_wr_en_q        <= 1'b0;
      mem_wr_addr_q      <= '0;
      mem_wr_data_q      <= '0;
      rw_done_q          <= 1'b0;
      ap_done_q          <= 1'b0;
      err_tccd_q         <= 1'b0;
      err_overflow_q     <= 1'b0;
      err_bus_conflict_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        q_wr_q[i]   <= 1'b0;
        q_ap_q[i]   <= 1'b0;
        q_bl4_q[i]  <= 1'b0;
        q_addr_q[i] <= '0;
        q_cnt_q[i]  <= '0;
      end
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      ap_q    <= ap_d;
      sp_q    <= sp_d;
      for (int i = 0; i < DEPTH; i++) begin
        q_wr_q[i]   <= q_wr_d[i];
        q_ap_q[i]   <= q_ap_d[i];
        q_bl4_q[i]  <= q_bl4_d[i];
        q_addr_q[i] <= q_addr_d[i];
        q_cnt_q[i]  <= q_cnt_d[i];
      end
      mem_wr_en_q        <= (state_q == BURST_WR);
      mem_wr_addr_q      <= (state_q == BURST_WR) ? addr_q + ADDR_W'(beat_q) : '0;
      mem_wr_data_q      <= (state_q == BURST_WR) ? dq_in : '0;
      rw_done_q          <= at_last;
      ap_done_q          <= at_last && ap_q;
      err_tccd_q         <= accept && (sp_q < tCCD);
      err_overflow_q     <= cas_valid && cmd_legal && full;
      err_bus_conflict_q <= drop;
    end
  end

  assign mem_wr_en        = mem_wr_en_q;
  assign mem_wr_addr      = mem_wr_addr_q;
  assign mem_wr_data      = mem_wr_data_q;
  assign dq_oe            = (state_q == BURST_RD);
  assign dq_out           = dq_oe ? mem_rd_data : '0;
  assign rw_done          = rw_done_q;
  assign ap_done          = ap_done_q;
  assign busy             = (count_q != '0) || (state_q != BURST_IDLE);
  assign err_tccd         = err_tccd_q;
  assign err_overflow     = err_overflow_q;
  assign err_bus_conflict = err_bus_conflict_q;

endmodule

// File: doc/ddr_cas_responder.md
Name: ddr_cas_responder

Overview:
- Device-side counterpart of the controller CAS path: accepts READ/WRITE (optionally auto-precharge) commands as the DRAM would see them and runs the data bursts with JEDEC-style latencies.
- Returns read data after RL = AL+CL and captures write data after WL = AL+CWL, using a pending-command queue.
- Drives rw_done back toward the controller and flags tCCD, overflow and bus-collision violations.
- Sits in the memory model / testbench side of the DDR subsystem, clocked by CK_t; data is packed one word per clock (both DDR edges in one word).

Parameters:
- ADDR_W, 10, column address width.
- DATA_W, 16, data word per CK_t cycle (2 x DQ width).
- DEPTH, 4, pending command queue entries.

Ports:
- CK_t, in, 1, clock.
- reset_n, in, 1, asynchronous active-low reset.
- CL / CWL / AL, in, 5 each, latency settings; sampled per command at acceptance.
- BL, in, 5, burst length: 8 gives 4 data cycles, 4 gives 2; any other value is treated as 8.
- tCCD, in, 4, minimum CAS-to-CAS spacing in cycles.
- cas_valid, in, 1, command strobe.
- cas_req, in, 3, RD_R/RDA_R/WR_R/WRA_R encodings from ddr_pkg.
- cas_addr, in, ADDR_W, starting column.
- mem_rd_en, out, 1, storage read strobe; mem_rd_addr, out, ADDR_W, its address.
- mem_rd_data, in, DATA_W, storage read data, valid 1 cycle after mem_rd_en.
- mem_wr_en, out, 1, storage write strobe; mem_wr_addr, out, ADDR_W; mem_wr_data, out, DATA_W.
- dq_out, out, DATA_W, read data; dq_oe, out, 1, read data valid/drive enable.
- dq_in, in, DATA_W, write data from controller.
- rw_done, out, 1, burst-complete pulse.
- ap_done, out, 1, auto-precharge-complete pulse.
- busy, out, 1, queue non-empty or burst active.
- err_tccd / err_overflow / err_bus_conflict, out, 1 each, 1-cycle violation pulses.

Behaviour:
- Reset (async, any time including mid-burst):
  - queue emptied, burst FSM to BURST_IDLE.
  - all outputs 0; tCCD spacing counter set to saturated (first command never flags).
- Acceptance, cycle T: cas_valid=1 and cas_req is one of the four legal codes.
  - Illegal codes are ignored silently.
  - Entry pushed: {is_wr, ap, addr, nbeats, countdown}.
  - countdown = lat-1, where lat = RL for reads, WL for writes; lat below 2 is clamped to 2.
  - Latency arithmetic is 6-bit unsigned.
- tCCD check: the spacing counter counts cycles since the last accepted command, saturating at 15.
  - If a new command is accepted with spacing < tCCD, err_tccd pulses at T+1.
  - The command is still accepted.
- Overflow: cas_valid with queue full (DEPTH entries) -> command dropped, err_overflow pulses at T+1.
- Every queued countdown decrements each cycle.
- Burst start: an entry reaching 0 at cycle S starts its burst at S+1, i.e. its first data cycle is T+lat.
- Read data timing:
  - mem_rd_en/mem_rd_addr are issued one cycle ahead of each data cycle.
  - dq_out=mem_rd_data with dq_oe=1 for cycles T+RL .. T+RL+nbeats-1.
  - The address increments by 1 per beat and wraps modulo 2^ADDR_W.
- Write data timing:
  - dq_in is sampled at cycles T+WL .. T+WL+nbeats-1.
  - mem_wr_en/addr/data are registered, appearing one cycle after each sampled beat.
- FSM states:
  - BURST_IDLE: waits for a started entry; goes to BURST_RD or BURST_WR.
  - BURST_RD / BURST_WR: beat counter 0..nbeats-1.
  - After the last beat: go to BURST_IDLE, or directly to the next burst if one starts the following cycle (gapless back-to-back allowed).
- rw_done: 1-cycle pulse in the cycle after the last data beat. ap_done pulses together with it when ap=1.
- Bus conflict: an entry whose start cycle falls while another burst still occupies its last beat or earlier is dropped, and err_bus_conflict pulses.
  - If two entries start in the same cycle, the older one wins and the younger is dropped with err_bus_conflict.
- A command accepted in the same cycle as a burst completion or queue pop is handled normally: the queue pops and pushes in the same cycle.
- busy = queue non-empty OR FSM not in BURST_IDLE.

Test Plan:
- Reset with CL=11, AL=0, BL=8, RD_R to addr 0x010 at T=0:
  - dq_oe high for T=11..14, data from addresses 0x010..0x013.
  - rw_done at T=15, ap_done stays 0.
- CWL=9, AL=2, WRA_R to addr 0x3FE with BL=4:
  - dq_in sampled at T=11,12.
  - mem_wr_en at T=12,13 to addresses 0x3FE, 0x3FF.
  - rw_done and ap_done both pulse at T=13.
- Two RD_R 4 cycles apart with tCCD=4, BL=8:
  - gapless dq_oe for 8 cycles.
  - a single rw_done after each burst.
  - no errors.
- Second command 2 cycles after the first with tCCD=4:
  - err_tccd at T=3.
  - err_bus_conflict when the second burst's start overlaps; only the first burst's data appears.
- 5 commands on consecutive cycles with DEPTH=4 and long CL: err_overflow on the 5th; 4 bursts are then processed or flagged as conflicts.
- reset_n deasserted during beat 2 of a read burst: dq_oe, busy, mem_rd_en are 0 immediately; no rw_done after reset release.
